// File: rtl/sw_alloc.sv
// Wormhole switch allocator for the 5-port router: per-output round-robin
// arbitration among head requests, lock held by the winner until its tail flit
// transfers; drives per-input flit grants and per-output crossbar selects.
// Latency: head request in cycle t -> first grant in t+1; one idle bubble cycle
// between consecutive packets on the same output.
// Backpressure: a locked output grants only when its owner has a flit (req) and
// downstream can accept (out_ready); otherwise the lock is simply held.
//
// Ports:
//   clk        clock
//   rst_       synchronous active-high reset
//   req        per-input: flit valid at buffer head
//   req_port   per-input target output, PORTW bits per input
//   req_tail   per-input: head-of-buffer flit is a tail
//   out_ready  per-output: downstream can accept a flit
//   grant      per-input: flit transfers this cycle (input pops on this)
//   out_valid  per-output: output carries a flit this cycle
//   out_sel    per-output crossbar select (driving input index), PORTW bits each
//   busy       per-output: output is locked to an owner
module sw_alloc #(
  parameter int NPORT = 5,
  parameter int PORTW = 3
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT*PORTW-1:0] req_port,
  input  logic [NPORT-1:0]       req_tail,
  input  logic [NPORT-1:0]       out_ready,
  output logic [NPORT-1:0]       grant,
  output logic [NPORT-1:0]       out_valid,
  output logic [NPORT*PORTW-1:0] out_sel,
  output logic [NPORT-1:0]       busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           state_q  [NPORT];
  state_e           state_d  [NPORT];
  logic [PORTW-1:0] owner_q  [NPORT];
  logic [PORTW-1:0] owner_d  [NPORT];
  logic [PORTW-1:0] rr_ptr_q [NPORT];
  logic [PORTW-1:0] rr_ptr_d [NPORT];

  // is_owner[i]: input i currently owns some output. Such an input is excluded
  // from every candidate set, which keeps grant one-hot per input and makes a
  // releasing owner wait for the idle cycle before its next head is seen.
  logic [NPORT-1:0] is_owner;
  // cand[o][i]: input i is a head candidate for output o.
  logic [NPORT-1:0] cand [NPORT];
  // xfer[o]: locked output o moves a flit this cycle.
  logic [NPORT-1:0] xfer;
  logic [NPORT-1:0] found;
  logic [PORTW:0]   scan_sum;
  logic [PORTW-1:0] scan_idx;

  always_comb begin
    is_owner = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (state_q[o] == ST_LOCKED) begin
        is_owner[owner_q[o]] = 1'b1;
      end
    end
  end

  // Targets >= NPORT never match any o, so such inputs are never candidates.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
        cand[o][i] = req[i] && (req_port[i*PORTW +: PORTW] == PORTW'(o)) && !is_owner[i];
      end
    end
  end

  // Per-output next state, locked-output datapath controls and arbitration.
  always_comb begin
    xfer      = '0;
    found     = '0;
    out_valid = '0;
    out_sel   = '0;
    busy      = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int o = 0; o < NPORT; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
      case (state_q[o])
        ST_LOCKED: begin
          xfer[o]                    = req[owner_q[o]] & out_ready[o];
          out_valid[o]               = xfer[o];
          out_sel[o*PORTW +: PORTW]  = owner_q[o];
          busy[o]                    = 1'b1;
          if (xfer[o] && req_tail[owner_q[o]]) begin
            state_d[o]  = ST_IDLE;
            // Previous owner goes to the back of the rotation.
            rr_ptr_d[o] = (owner_q[o] == PORTW'(NPORT-1)) ? '0 : owner_q[o] + 1'b1;
          end
        end
        default: begin
          // Scan from rr_ptr upward, wrapping modulo NPORT; first hit wins.
          // No grant in this cycle: the lock takes effect next cycle.
          for (int k = 0; k < NPORT; k++) begin
            scan_sum = {1'b0, rr_ptr_q[o]} + (PORTW+1)'(k);
            if (scan_sum >= (PORTW+1)'(NPORT)) begin
              scan_sum = scan_sum - (PORTW+1)'(NPORT);
            end
            scan_idx = scan_sum[PORTW-1:0];
            if (!found[o] && cand[o][scan_idx]) begin
              found[o]   = 1'b1;
              owner_d[o] = scan_idx;
              state_d[o] = ST_LOCKED;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NPORT; i++) begin
      for (int o = 0; o < NPORT; o++) begin
        if (xfer[o] && (owner_q[o] == PORTW'(i))) begin
          grant[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NPORT; o++) begin
      if (rst_) begin
        state_q[o]  <= ST_IDLE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= '0;
      end else begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
      end
    end
  end

endmodule

// File: tb/tb_sw_alloc.sv
// Directed bench for sw_alloc. A small upstream model (per-input packet
// length / packets remaining) supplies req/req_port/req_tail and pops on grant;
// every expected value comes from hand-computed per-cycle tables.
module tb_sw_alloc;
  localparam int NPORT = 5;
  localparam int PORTW = 3;

  logic        clk = 1'b0;
  logic        rst_;
  logic [4:0]  req;
  logic [14:0] req_port;
  logic [4:0]  req_tail;
  logic [4:0]  out_ready;
  logic [4:0]  grant;
  logic [4:0]  out_valid;
  logic [14:0] out_sel;
  logic [4:0]  busy;

  int n_checks = 0;
  int n_fail   = 0;

  int left [5];
  int len  [5];
  int npkt [5];
  int port [5];

  always #5 clk = ~clk;

  sw_alloc #(.NPORT(NPORT), .PORTW(PORTW)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .req      (req),
    .req_port (req_port),
    .req_tail (req_tail),
    .out_ready(out_ready),
    .grant    (grant),
    .out_valid(out_valid),
    .out_sel  (out_sel),
    .busy     (busy)
  );

  task automatic load(input int i, input int p, input int l, input int n);
    port[i] = p;
    len[i]  = l;
    left[i] = l;
    npkt[i] = n;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 5; i++) begin
      left[i] = 0;
      len[i]  = 0;
      npkt[i] = 0;
      port[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      req[i]             = (left[i] > 0);
      req_port[i*3 +: 3] = 3'(port[i]);
      req_tail[i]        = (left[i] == 1);
    end
  endtask

  // Advance one cycle; inputs change 1 ns after the edge, outputs are
  // observed 2 ns after the edge.
  task automatic cycle(input logic [4:0] rdy);
    @(posedge clk);
    #1;
    out_ready = rdy;
    drive();
    #1;
  endtask

  task automatic pop();
    for (int i = 0; i < 5; i++) begin
      if (grant[i] && left[i] > 0) begin
        left[i]--;
        if (left[i] == 0 && npkt[i] > 0) begin
          npkt[i]--;
          left[i] = len[i];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b1;
    cycle(5'h1f);
    cycle(5'h1f);
    n_checks++; if (grant !== 5'h00) begin n_fail++; $display("FAIL reset_grant: got %b expected %b", grant, 5'h00); end
    n_checks++; if (out_valid !== 5'h00) begin n_fail++; $display("FAIL reset_out_valid: got %b expected %b", out_valid, 5'h00); end
    n_checks++; if (out_sel !== 15'h0) begin n_fail++; $display("FAIL reset_out_sel: got %h expected %h", out_sel, 15'h0); end
    n_checks++; if (busy !== 5'h00) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", busy, 5'h00); end
    rst_ = 1'b0;
  endtask

  // Single-flit 0->1, then 0 and 1 race for output 1: rr_ptr[1]=1 favours 1.
  task automatic test_single();
    logic [4:0] eg [8];
    logic [4:0] eb [8];
    logic [2:0] es [8];
    eg = '{5'h00, 5'h01, 5'h00, 5'h00, 5'h02, 5'h00, 5'h01, 5'h00};
    eb = '{5'h00, 5'h02, 5'h00, 5'h00, 5'h02, 5'h00, 5'h02, 5'h00};
    es = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
    load(0, 1, 1, 0);
    for (int c = 0; c < 8; c++) begin
      cycle(5'h1f);
      n_checks++; if (grant !== eg[c]) begin n_fail++; $display("FAIL single_grant c%0d: got %b expected %b", c, grant, eg[c]); end
      n_checks++; if (busy !== eb[c]) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy, eb[c]); end
      n_checks++; if (out_valid !== eb[c]) begin n_fail++; $display("FAIL single_out_valid c%0d: got %b expected %b", c, out_valid, eb[c]); end
      n_checks++; if (out_sel[5:3] !== es[c]) begin n_fail++; $display("FAIL single_sel1 c%0d: got %0d expected %0d", c, out_sel[5:3], es[c]); end
      pop();
      if (c == 2) begin
        load(0, 1, 1, 0);
        load(1, 1, 1, 0);
      end
    end
    clear_all();
  endtask

  // Inputs 0, 2, 4 stream 2-flit packets to output 3: order 0, 2, 4, 0.
  task automatic test_round_robin();
    logic [4:0] eg [12];
    logic [2:0] es [12];
    logic [4:0] eb;
    eg = '{5'h00, 5'h01, 5'h01, 5'h00, 5'h04, 5'h04, 5'h00, 5'h10, 5'h10, 5'h00, 5'h01, 5'h01};
    es = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0};
    load(0, 3, 2, 1);
    load(2, 3, 2, 1);
    load(4, 3, 2, 1);
    for (int c = 0; c < 12; c++) begin
      cycle(5'h1f);
      eb = (eg[c] != 5'h00) ? 5'h08 : 5'h00;
      n_checks++; if (grant !== eg[c]) begin n_fail++; $display("FAIL rr_grant c%0d: got %b expected %b", c, grant, eg[c]); end
      n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL rr_busy c%0d: got %b expected %b", c, busy, eb); end
      n_checks++; if (out_valid !== eb) begin n_fail++; $display("FAIL rr_out_valid c%0d: got %b expected %b", c, out_valid, eb); end
      n_checks++; if (out_sel[11:9] !== es[c]) begin n_fail++; $display("FAIL rr_sel3 c%0d: got %0d expected %0d", c, out_sel[11:9], es[c]); end
      pop();
    end
    clear_all();
    cycle(5'h1f);
    n_checks++; if (busy !== 5'h00) begin n_fail++; $display("FAIL rr_release_busy: got %b expected %b", busy, 5'h00); end
  endtask

  // Input 1 sends 3 flits to output 4 with out_ready[4] low for 3 cycles.
  task automatic test_backpressure();
    logic [4:0] rdy [8];
    logic [4:0] eg  [8];
    logic [4:0] eb  [8];
    logic [4:0] ev;
    rdy = '{5'h1f, 5'h1f, 5'h0f, 5'h0f, 5'h0f, 5'h1f, 5'h1f, 5'h1f};
    eg  = '{5'h00, 5'h02, 5'h00, 5'h00, 5'h00, 5'h02, 5'h02, 5'h00};
    eb  = '{5'h00, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00};
    load(1, 4, 3, 0);
    for (int c = 0; c < 8; c++) begin
      cycle(rdy[c]);
      ev = (eg[c] != 5'h00) ? 5'h10 : 5'h00;
      n_checks++; if (grant !== eg[c]) begin n_fail++; $display("FAIL bp_grant c%0d: got %b expected %b", c, grant, eg[c]); end
      n_checks++; if (busy !== eb[c]) begin n_fail++; $display("FAIL bp_busy c%0d: got %b expected %b", c, busy, eb[c]); end
      n_checks++; if (out_valid !== ev) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b expected %b", c, out_valid, ev); end
      n_checks++; if (out_sel[14:12] !== ((eb[c] != 5'h00) ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL bp_sel4 c%0d: got %0d", c, out_sel[14:12]); end
      pop();
    end
    clear_all();
  endtask

  // 0->2 (2 flits), 1->2, 3->0 together: outputs 2 and 0 lock at once.
  task automatic test_parallel();
    logic [4:0] eg [6];
    logic [4:0] eb [6];
    logic [2:0] s2 [6];
    logic [2:0] s0 [6];
    eg = '{5'h00, 5'h09, 5'h01, 5'h00, 5'h02, 5'h00};
    eb = '{5'h00, 5'h05, 5'h04, 5'h00, 5'h04, 5'h00};
    s2 = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    s0 = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
    load(0, 2, 2, 0);
    load(1, 2, 1, 0);
    load(3, 0, 1, 0);
    for (int c = 0; c < 6; c++) begin
      cycle(5'h1f);
      n_checks++; if (grant !== eg[c]) begin n_fail++; $display("FAIL par_grant c%0d: got %b expected %b", c, grant, eg[c]); end
      n_checks++; if (busy !== eb[c]) begin n_fail++; $display("FAIL par_busy c%0d: got %b expected %b", c, busy, eb[c]); end
      n_checks++; if (out_valid !== eb[c]) begin n_fail++; $display("FAIL par_out_valid c%0d: got %b expected %b", c, out_valid, eb[c]); end
      n_checks++; if (out_sel[8:6] !== s2[c]) begin n_fail++; $display("FAIL par_sel2 c%0d: got %0d expected %0d", c, out_sel[8:6], s2[c]); end
      n_checks++; if (out_sel[2:0] !== s0[c]) begin n_fail++; $display("FAIL par_sel0 c%0d: got %0d expected %0d", c, out_sel[2:0], s0[c]); end
      pop();
    end
    clear_all();
  endtask

  // Input 3 uses output 2 to set rr_ptr[2]=4; then 1 and 3 race (1 wins),
  // then 0 and 3 race with rr_ptr[2]=2 (3 wins), then 0.
  task automatic test_wrap();
    logic [4:0] eg [9];
    logic [2:0] es [9];
    logic [4:0] eb;
    eg = '{5'h00, 5'h08, 5'h00, 5'h02, 5'h00, 5'h08, 5'h00, 5'h01, 5'h00};
    es = '{3'd0, 3'd3, 3'd0, 3'd1, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0};
    load(3, 2, 1, 0);
    for (int c = 0; c < 9; c++) begin
      cycle(5'h1f);
      eb = (eg[c] != 5'h00) ? 5'h04 : 5'h00;
      n_checks++; if (grant !== eg[c]) begin n_fail++; $display("FAIL wrap_grant c%0d: got %b expected %b", c, grant, eg[c]); end
      n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL wrap_busy c%0d: got %b expected %b", c, busy, eb); end
      n_checks++; if (out_sel[8:6] !== es[c]) begin n_fail++; $display("FAIL wrap_sel2 c%0d: got %0d expected %0d", c, out_sel[8:6], es[c]); end
      pop();
      if (c == 1) begin
        load(1, 2, 1, 0);
        load(3, 2, 1, 0);
      end
      if (c == 2) begin
        load(0, 2, 1, 0);
      end
    end
    clear_all();
  endtask

  // Targets 7 and 5 are out of range: never granted, nothing locks.
  task automatic test_bad_port();
    load(4, 7, 1, 0);
    load(3, 5, 1, 0);
    for (int c = 0; c < 3; c++) begin
      cycle(5'h1f);
      n_checks++; if (grant !== 5'h00) begin n_fail++; $display("FAIL badport_grant c%0d: got %b expected %b", c, grant, 5'h00); end
      n_checks++; if (busy !== 5'h00) begin n_fail++; $display("FAIL badport_busy c%0d: got %b expected %b", c, busy, 5'h00); end
      pop();
    end
    clear_all();
  endtask

  // Reset while input 2 holds output 1 mid-packet; rr_ptr[1] (1 before)
  // returns to 0, so input 0 beats input 1 afterwards.
  task automatic test_reset_mid();
    logic [4:0] eg [5];
    logic [4:0] eb [5];
    logic [2:0] es [5];
    eg = '{5'h00, 5'h01, 5'h00, 5'h02, 5'h00};
    eb = '{5'h00, 5'h02, 5'h00, 5'h02, 5'h00};
    es = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    load(2, 1, 3, 0);
    cycle(5'h1f);
    n_checks++; if (grant !== 5'h00) begin n_fail++; $display("FAIL rstmid_arb_grant: got %b expected %b", grant, 5'h00); end
    pop();
    cycle(5'h1f);
    n_checks++; if (grant !== 5'h04) begin n_fail++; $display("FAIL rstmid_head_grant: got %b expected %b", grant, 5'h04); end
    n_checks++; if (out_sel[5:3] !== 3'd2) begin n_fail++; $display("FAIL rstmid_head_sel1: got %0d expected %0d", out_sel[5:3], 3'd2); end
    pop();
    cycle(5'h1f);
    rst_ = 1'b1;
    n_checks++; if (busy !== 5'h02) begin n_fail++; $display("FAIL rstmid_locked_busy: got %b expected %b", busy, 5'h02); end
    clear_all();
    cycle(5'h1f);
    rst_ = 1'b0;
    n_checks++; if (busy !== 5'h00) begin n_fail++; $display("FAIL rstmid_busy: got %b expected %b", busy, 5'h00); end
    n_checks++; if (grant !== 5'h00) begin n_fail++; $display("FAIL rstmid_grant: got %b expected %b", grant, 5'h00); end
    n_checks++; if (out_valid !== 5'h00) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected %b", out_valid, 5'h00); end
    n_checks++; if (out_sel !== 15'h0) begin n_fail++; $display("FAIL rstmid_out_sel: got %h expected %h", out_sel, 15'h0); end
    load(0, 1, 1, 0);
    load(1, 1, 1, 0);
    for (int c = 0; c < 5; c++) begin
      cycle(5'h1f);
      n_checks++; if (grant !== eg[c]) begin n_fail++; $display("FAIL rstmid_post_grant c%0d: got %b expected %b", c, grant, eg[c]); end
      n_checks++; if (busy !== eb[c]) begin n_fail++; $display("FAIL rstmid_post_busy c%0d: got %b expected %b", c, busy, eb[c]); end
      n_checks++; if (out_sel[5:3] !== es[c]) begin n_fail++; $display("FAIL rstmid_post_sel1 c%0d: got %0d expected %0d", c, out_sel[5:3], es[c]); end
      pop();
    end
    clear_all();
  endtask

  initial begin
    rst_      = 1'b1;
    out_ready = 5'h1f;
    clear_all();
    drive();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_parallel();
    test_wrap();
    test_bad_port();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_alloc.md
Name: sw_alloc

Overview:
- Wormhole switch allocator for the 5-port router. Shares each output port between the input ports whose route-computation result targets it.
- Per output: round-robin arbitration among head requests; the winner holds the output until its tail flit transfers.
- Drives per-input flit grants and per-output crossbar selects. Sits between the input buffers/route computation and the crossbar.

Parameters:
- NPORT, 5, number of input and output ports (0 N, 1 E, 2 S, 3 W, 4 local).
- PORTW, 3, width of an encoded port number.

Ports:
- clk  input  1  clock.
- rst_  input  1  reset; synchronous, active-high.
- req  input  NPORT  req[i]: input i has a valid flit at its buffer head.
- req_port  input  NPORT*PORTW  target output of input i, in bits [i*PORTW +: PORTW]. Held stable from head to tail.
- req_tail  input  NPORT  req_tail[i]: the head-of-buffer flit of input i is a tail flit. A single-flit packet has head and tail in the same flit.
- out_ready  input  NPORT  out_ready[o]: downstream of output o can accept a flit this cycle (credit available).
- grant  output  NPORT  grant[i]: the flit of input i transfers through the crossbar this cycle. Input i pops its buffer on this signal.
- out_valid  output  NPORT  out_valid[o]: output o carries a flit this cycle.
- out_sel  output  NPORT*PORTW  input index driving output o, in bits [o*PORTW +: PORTW].
- busy  output  NPORT  busy[o]: output o is locked to an owner.

Behaviour:
- Per-output state: IDLE or LOCKED. Registers per output: owner[o] (PORTW bits) and rr_ptr[o] (PORTW bits, range 0..NPORT-1).
- Reset (rst_=1 at a clk edge):
  - All outputs go to IDLE; owner=0; rr_ptr=0.
  - Outputs grant=0, out_valid=0, out_sel=0, busy=0 from the next cycle on.
  - Reset mid-packet drops every lock with no tail required. Requesters are reset in the same cycle.
- Candidate set for output o: inputs i with req[i]=1, req_port[i]==o, and input i not currently owner of any output.
- IDLE → LOCKED:
  - When the candidate set is non-empty, choose the first candidate scanning i = rr_ptr[o], rr_ptr[o]+1, … modulo NPORT.
  - Register owner[o]=winner; LOCKED is entered next cycle.
  - No grant is issued in the arbitration cycle. Minimum head latency: req asserted in cycle t → first grant in cycle t+1.
- LOCKED, combinational within the cycle:
  - grant[owner] = req[owner] & out_ready[o].
  - out_valid[o] = that same term.
  - out_sel[o] = owner[o].
  - busy[o] = 1.
- LOCKED → IDLE: when grant[owner] & req_tail[owner] in cycle t.
  - Next cycle: state = IDLE, rr_ptr[o] = (owner+1) mod NPORT (wrap 4→0), busy = 0.
  - Released output re-arbitrates in cycle t+1 and grants from t+2. One bubble cycle between packets on the same output is required.
- Flow control:
  - req[owner]=0 while LOCKED (upstream bubble): no grant, lock held.
  - out_ready[o]=0: no grant, lock held, no flit lost.
- IDLE outputs: out_valid=0, out_sel=0.
- req_port values ≥ NPORT are never candidates for any output, so that input is never granted.
- Independence:
  - Each output arbitrates independently.
  - One input owns at most one output. Exclusion via the candidate rule makes grant one-hot per input.
  - Several outputs may lock in the same cycle to different inputs.
- Simultaneous events:
  - Two outputs never pick the same input, because the input requests one port only.
  - A tail grant and a new head request for the same output in the same cycle: the request waits for the IDLE cycle.
- rr_ptr changes only on release, never on arbitration. A new head from the previous owner is served last in the rotation.
- No other state. Target implementation: 150–250 lines.

Test Plan:
- Reset then single request: rst_ 1→0; req[0]=1, req_port[0]=1, req_tail[0]=1, out_ready=all 1 at cycle t → busy[1]=1 at t+1, grant[0]=1, out_valid[1]=1, out_sel[1]=0 at t+1. IDLE and busy[1]=0 at t+2; rr_ptr[1]=1.
- Round-robin fairness: inputs 0, 2 and 4 each send continuous 2-flit packets to output 3 → order of ownership on output 3 is 0, 2, 4, 0, … Exactly one bubble cycle between consecutive packets; no input starved.
- Backpressure mid-packet: input 1 owns output 4 with a 3-flit packet; out_ready[4]=0 for cycles 2–4 of the packet → grant[1]=0 in those cycles, busy[4] stays 1. Remaining flits transfer after out_ready returns; release only after the tail grant.
- Parallel allocation and exclusion: input 0→port 2, input 1→port 2, input 3→port 0 in the same cycle → outputs 2 and 0 both lock next cycle (owner 0 and 3). Input 1 is granted only after input 0's tail plus the IDLE cycle.
- Wrap-around: rr_ptr[2]=4, requesters inputs 1 and 3 → input 1 wins (scan 4, 0, 1). After release, rr_ptr[2]=2.
- Reset mid-packet: rst_=1 while output 1 is LOCKED with no tail sent → next cycle busy=0, grant=0, out_sel=0, rr_ptr=0. A fresh request after reset allocates normally with 1-cycle latency.
